mem_access_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the core's decode/execute stage and the data-memory bus. It takes the decoded memory access type, the sign-extension flag, the ALU-computed address and the store data, and runs one request/acknowledge transaction on a word-wide bus with byte enables. While the transaction is in flight it holds the core with `stall`, then returns the aligned, extended load value for register writeback. It also flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: issues one request/acknowledge bus transaction per memory
// instruction, stalls the core while it is in flight and returns the extended load data.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CPU_WIDTH = 32,
  localparam int unsigned MEM_ACCESS_TYPE_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] mem_access_type,
  input  logic                             mem_sign_ext,
  input  logic [CPU_WIDTH-1:0]             addr,
  input  logic [CPU_WIDTH-1:0]             wdata,
  output logic                             stall,
  output logic [CPU_WIDTH-1:0]             rdata,
  output logic                             rdata_valid,
  output logic                             misalign,
  output logic                             bus_err,
  output logic                             bus_req,
  output logic                             bus_we,
  output logic [CPU_WIDTH-1:0]             bus_addr,
  output logic [CPU_WIDTH-1:0]             bus_wdata,
  output logic [3:0]                       bus_be,
  input  logic                             bus_ack,
  input  logic [CPU_WIDTH-1:0]             bus_rdata
);

  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_NONE       = 3'd0;
  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_BYTE  = 3'd1;
  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_HALF  = 3'd2;
  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_WORD  = 3'd3;
  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_BYTE = 3'd4;
  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_HALF = 3'd5;
  localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_WORD = 3'd6;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  acc_size_t        size_q, size_d;
  logic             sign_q, sign_d;

  logic                 bus_req_d, bus_we_d, rdata_valid_d, bus_err_d;
  logic [CPU_WIDTH-1:0] bus_addr_d, bus_wdata_d, rdata_d;
  logic [3:0]           bus_be_d;

  logic                 req_valid, req_we, req_misalign;
  acc_size_t            req_size;
  logic [3:0]           req_be;
  logic [CPU_WIDTH-1:0] req_wdata, sel, load_val;
  logic                 timeout_hit;

  // Decode the incoming access kind.
  always_comb begin
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_BYTE;
    case (mem_access_type)
      MEM_ACCESS_TYPE_READ_BYTE:  req_size = SZ_BYTE;
      MEM_ACCESS_TYPE_READ_HALF:  req_size = SZ_HALF;
      MEM_ACCESS_TYPE_READ_WORD:  req_size = SZ_WORD;
      MEM_ACCESS_TYPE_WRITE_BYTE: begin req_we = 1'b1; req_size = SZ_BYTE; end
      MEM_ACCESS_TYPE_WRITE_HALF: begin req_we = 1'b1; req_size = SZ_HALF; end
      MEM_ACCESS_TYPE_WRITE_WORD: begin req_we = 1'b1; req_size = SZ_WORD; end
      MEM_ACCESS_TYPE_NONE:       req_valid = 1'b0;
      default:                    req_valid = 1'b0;
    endcase
  end

  assign req_misalign = ((req_size == SZ_HALF) && addr[0]) ||
                        ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Byte-lane enables and replicated store data.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = wdata;
    case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down and extend it.
  assign sel = bus_rdata >> {off_q, 3'b000};
  always_comb begin
    load_val = bus_rdata;
    case (size_q)
      SZ_BYTE: load_val = {{24{sign_q & sel[7]}}, sel[7:0]};
      SZ_HALF: load_val = {{16{sign_q & sel[15]}}, sel[15:0]};
      default: ;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(TIMEOUT_CYCLES));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    off_d         = off_q;
    size_d        = size_q;
    sign_d        = sign_q;
    stall         = 1'b0;
    misalign      = 1'b0;
    bus_req_d     = bus_req;
    bus_we_d      = bus_we;
    bus_addr_d    = bus_addr;
    bus_wdata_d   = bus_wdata;
    bus_be_d      = bus_be;
    rdata_d       = rdata;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_misalign) begin
            misalign = 1'b1;
          end else begin
            stall       = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {addr[CPU_WIDTH-1:2], 2'b00};
            bus_wdata_d = req_wdata;
            bus_be_d    = req_be;
            off_d       = addr[1:0];
            size_d      = req_size;
            sign_d      = mem_sign_ext;
            cnt_d       = '0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we) begin
            rdata_d       = load_val;
            rdata_valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= SZ_BYTE;
      sign_q      <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      bus_be      <= bus_be_d;
      rdata       <= rdata_d;
      rdata_valid <= rdata_valid_d;
      bus_err     <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and random accesses checked against
// an arithmetic model of byte lanes/extension, plus timeout and mid-operation reset.
module tb_mem_access_ctrl;

  localparam logic [2:0] T_NONE = 3'd0, T_RB = 3'd1, T_RH = 3'd2, T_RW = 3'd3;
  localparam logic [2:0] T_WB = 3'd4, T_WH = 3'd5, T_WW = 3'd6;

  logic        clk, rst;
  logic [2:0]  mem_access_type;
  logic        mem_sign_ext;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_ack, ack_to;

  logic        stall, rdata_valid, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall_to, rdata_valid_to, misalign_to, bus_err_to, bus_req_to, bus_we_to;
  logic [31:0] rdata_to, bus_addr_to, bus_wdata_to;
  logic [3:0]  bus_be_to;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = '0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_access_type(mem_access_type), .mem_sign_ext(mem_sign_ext),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  mem_access_ctrl #(.TIMEOUT_CYCLES(3)) dut_to (
    .clk(clk), .rst(rst), .mem_access_type(mem_access_type), .mem_sign_ext(mem_sign_ext),
    .addr(addr), .wdata(wdata), .stall(stall_to), .rdata(rdata_to),
    .rdata_valid(rdata_valid_to), .misalign(misalign_to), .bus_err(bus_err_to),
    .bus_req(bus_req_to), .bus_we(bus_we_to), .bus_addr(bus_addr_to),
    .bus_wdata(bus_wdata_to), .bus_be(bus_be_to), .bus_ack(ack_to), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] t);
    if (t == T_RB || t == T_WB) return 1;
    if (t == T_RH || t == T_WH) return 2;
    return 4;
  endfunction

  function automatic bit is_rd(input logic [2:0] t);
    return (t == T_RB || t == T_RH || t == T_RW);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] t, input logic [31:0] a);
    int m;
    m = (1 << nbytes(t)) - 1;
    return 4'(m << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] wd);
    if (nbytes(t) == 1) return (wd % 256) * 32'h0101_0101;
    if (nbytes(t) == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] t, input logic sx,
                                           input logic [31:0] a, input logic [31:0] word);
    longint v, span;
    int n;
    n = nbytes(t);
    span = longint'(1) << (8 * n);
    v = (longint'(word) >> (8 * (a % 4))) % span;
    if (sx && n < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One aligned access on the default-timeout DUT; ack arrives in REQ cycle lat.
  task automatic do_access(input logic [2:0] t, input logic sx, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] word, input int lat);
    mem_access_type = t; mem_sign_ext = sx; addr = a; wdata = wd;
    bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    chk("issue_stall", 32'(stall), 32'(1));
    chk("issue_misalign", 32'(misalign), 32'(0));
    chk("idle_bus_req", 32'(bus_req), 32'(0));
    chk("idle_rdata_valid", 32'(rdata_valid), 32'(0));
    for (int k = 1; k <= lat; k++) begin
      tick();
      bus_ack = (k == lat);
      bus_rdata = (k == lat) ? word : $urandom;
      @(negedge clk);
      chk("req_bus_req", 32'(bus_req), 32'(1));
      chk("req_stall", 32'(stall), 32'(1));
      chk("req_bus_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_bus_we", 32'(bus_we), 32'(!is_rd(t)));
      chk("req_bus_be", 32'(bus_be), 32'(exp_be(t, a)));
      if (!is_rd(t)) chk("req_bus_wdata", bus_wdata, exp_wdata(t, wd));
    end
    tick();
    bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    if (is_rd(t)) exp_rd = exp_load(t, sx, a, word);
    chk("done_stall", 32'(stall), 32'(0));
    chk("done_bus_req", 32'(bus_req), 32'(0));
    chk("done_rdata_valid", 32'(rdata_valid), 32'(is_rd(t)));
    chk("done_bus_err", 32'(bus_err), 32'(0));
    chk("done_rdata", rdata, exp_rd);
    tick();
  endtask

  task automatic do_misalign(input logic [2:0] t, input logic [31:0] a);
    mem_access_type = t; mem_sign_ext = 1'b0; addr = a; wdata = $urandom;
    @(negedge clk);
    chk("mis_flag", 32'(misalign), 32'(1));
    chk("mis_stall", 32'(stall), 32'(0));
    chk("mis_bus_req", 32'(bus_req), 32'(0));
    tick();
    @(negedge clk);
    chk("mis_bus_req_next", 32'(bus_req), 32'(0));
    mem_access_type = T_NONE;
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_access_type = T_NONE; mem_sign_ext = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; ack_to = 1'b0; bus_rdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_misalign", 32'(misalign), 32'(0));
    chk("rst_bus_req", 32'(bus_req), 32'(0));
    chk("rst_rdata", rdata, 32'(0));
    chk("rst_rdata_valid", 32'(rdata_valid), 32'(0));
    chk("rst_bus_err", 32'(bus_err), 32'(0));
    chk("rst_bus_be", 32'(bus_be), 32'(0));
    chk("rst_bus_addr", bus_addr, 32'(0));
    tick();
    rst = 1'b0;

    do_access(T_RW, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1);
    do_access(T_RB, 1'b1, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
    do_access(T_RH, 1'b0, 32'h0000_0102, 32'h0, 32'h8000_0000, 1);
    do_access(T_WH, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 4);
    do_misalign(T_RW, 32'h0000_0101);
    do_misalign(T_RH, 32'h0000_0103);
    do_misalign(T_WW, 32'h0000_0202);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  t;
      logic [31:0] a;
      int n;
      t = 3'($urandom_range(1, 6));
      a = $urandom;
      n = nbytes(t);
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      if ((a % n) != 0) do_misalign(t, a);
      else do_access(t, 1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(1, 6));
    end

    // Reset during the second REQ cycle; a late ack must be ignored.
    mem_access_type = T_RW; addr = 32'h0000_0300; bus_ack = 1'b0;
    tick();
    tick();
    rst = 1'b1; mem_access_type = T_NONE;
    tick();
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    exp_rd = '0;
    chk("rstmid_bus_req", 32'(bus_req), 32'(0));
    chk("rstmid_stall", 32'(stall), 32'(0));
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rstmid_late_valid", 32'(rdata_valid), 32'(0));
    chk("rstmid_rdata", rdata, exp_rd);
    tick();
    @(negedge clk);
    chk("rstmid_late_valid2", 32'(rdata_valid), 32'(0));

    // Timeout behaviour on the TIMEOUT_CYCLES=3 instance.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mem_access_type = T_RW; mem_sign_ext = 1'b0; addr = 32'h0000_0040;
    tick();
    ack_to = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    ack_to = 1'b0;
    @(negedge clk);
    chk("to_pre_valid", 32'(rdata_valid_to), 32'(1));
    chk("to_pre_rdata", rdata_to, 32'hCAFE_F00D);
    tick();
    @(negedge clk);
    chk("to_idle_req", 32'(bus_req_to), 32'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("to_req_high", 32'(bus_req_to), 32'(1));
      chk("to_req_err", 32'(bus_err_to), 32'(0));
    end
    tick();
    mem_access_type = T_NONE;
    @(negedge clk);
    chk("to_done_req", 32'(bus_req_to), 32'(0));
    chk("to_done_err", 32'(bus_err_to), 32'(1));
    chk("to_done_rdata", rdata_to, 32'(0));
    chk("to_done_valid", 32'(rdata_valid_to), 32'(0));
    chk("to_done_stall", 32'(stall_to), 32'(0));
    tick();
    @(negedge clk);
    chk("to_after_err", 32'(bus_err_to), 32'(0));
    chk("to_after_req", 32'(bus_req_to), 32'(0));

    // Ack in the same cycle as expiry takes precedence.
    mem_access_type = T_RW; addr = 32'h0000_0044;
    tick();
    tick();
    tick();
    ack_to = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    ack_to = 1'b0; mem_access_type = T_NONE;
    @(negedge clk);
    chk("ackwin_valid", 32'(rdata_valid_to), 32'(1));
    chk("ackwin_err", 32'(bus_err_to), 32'(0));
    chk("ackwin_rdata", rdata_to, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
